pkt_arb_mux: RTL and testbench

- Packet-level grant consumer that sits directly downstream of the round-robin arbiter.
- Presents per-port packet-valid as the arbiter's request vector, latches the one-hot grant, and locks onto the granted port until its last beat.
- Muxes that port's beats into a single registered valid/ready output stream tagged with the binary port index.
- Used in front of shared egress resources: switch output port, shared DMA engine.

---
 rtl/pkt_arb_pkg.sv | 33 +++
 rtl/pkt_arb_mux_onehot_to_bin.sv | 22 ++
 rtl/pkt_arb_mux.sv | 146 ++++++++++++++
 tb/tb_pkt_arb_mux.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet arbitration mux: FSM state encoding,
// default port-index width and the grant legality check.
package pkt_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Default port count and the matching binary port-index width.
    localparam int DEF_PORTNUM = 16;
    localparam int DEF_PORT_W  = $clog2(DEF_PORTNUM);

    // Widest grant vector the legality check accepts. Callers zero-extend
    // their vectors, and extra zero grant bits never make a grant illegal.
    localparam int MAX_PORTS = 256;

    // A grant is legal when exactly one bit is set and that bit belongs to a
    // port that is actually requesting.
    function automatic logic onehot_is_legal(
        input logic [MAX_PORTS-1:0] gnt,
        input logic [MAX_PORTS-1:0] req
    );
        logic nonzero;
        logic single;
        logic requested;
        nonzero   = (gnt != '0);
        single    = ((gnt & (gnt - 1'b1)) == '0);
        requested = ((gnt & ~req) == '0);
        return nonzero && single && requested;
    endfunction

endpackage

// File: rtl/pkt_arb_mux_onehot_to_bin.sv
// One-hot to binary encoder. With a legal one-hot input the output is the
// index of the set bit. Any other input ORs the indices together, so the
// caller must qualify the input before using the result.
module onehot_to_bin #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [BIN_WIDTH-1:0]    bin
);

    // OR together the indices of all set bits.
    always_comb begin
        bin = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | BIN_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/pkt_arb_mux.sv
// Packet-level grant consumer behind a round-robin arbiter. In IDLE it offers
// the per-port packet-valid vector as requests and latches a legal one-hot
// grant. In XFER it stays on the granted port until that port's last beat,
// and forwards each beat through a single registered valid/ready stage tagged
// with the source port index.
module pkt_arb_mux
    import pkt_arb_pkg::*;
#(
    parameter int PORTNUM = 16,
    parameter int DW      = 32,
    parameter int PORT_W  = $clog2(PORTNUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORTNUM-1:0]    in_valid,
    input  logic [PORTNUM*DW-1:0] in_data,
    input  logic [PORTNUM-1:0]    in_last,
    output logic [PORTNUM-1:0]    in_ready,
    output logic [PORTNUM-1:0]    arb_req,
    output logic                  arb_schedule_en,
    input  logic [PORTNUM-1:0]    arb_gnt,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    output logic [PORT_W-1:0]     out_port,
    input  logic                  out_ready,
    output logic                  gnt_err
);

    state_t              state;
    logic [PORTNUM-1:0]  sel_oh;
    logic [PORT_W-1:0]   sel_bin;
    logic [PORT_W-1:0]   gnt_bin;
    logic                gnt_legal;
    logic                load_ok;
    logic                sel_valid;
    logic                sel_last;
    logic [DW-1:0]       sel_data;
    logic                accept;

    onehot_to_bin #(
        .ONEHOT_WIDTH (PORTNUM),
        .BIN_WIDTH    (PORT_W)
    ) u_gnt_enc (
        .onehot (arb_gnt),
        .bin    (gnt_bin)
    );

    // The grant is only trusted when it is one-hot and lands on a port that
    // is currently presenting a beat.
    assign gnt_legal = onehot_is_legal(MAX_PORTS'(arb_gnt), MAX_PORTS'(in_valid));

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this cycle, giving one beat per cycle in a packet.
    assign load_ok = !out_valid || out_ready;

    // AND-OR mux over the latched one-hot select. This keeps the data path
    // free of a wide binary-indexed shifter, and a zero select yields zeros.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < PORTNUM; i++) begin
            if (sel_oh[i]) begin
                sel_valid = sel_valid | in_valid[i];
                sel_last  = sel_last  | in_last[i];
                sel_data  = sel_data  | in_data[i*DW +: DW];
            end
        end
    end

    assign accept = (state == XFER) && sel_valid && load_ok;

    // Arbiter requests are only offered while idle. Only the locked port
    // ever sees ready, and only when the output stage has room.
    always_comb begin
        arb_req         = '0;
        arb_schedule_en = 1'b0;
        in_ready        = '0;
        case (state)
            IDLE: begin
                arb_req         = in_valid;
                arb_schedule_en = |in_valid;
            end
            XFER: begin
                in_ready = sel_oh & {PORTNUM{load_ok}};
            end
            default: begin
                arb_req = '0;
            end
        endcase
    end

    // Packet FSM: latch a legal grant in IDLE, hold the port through XFER
    // until its last beat is accepted, and flag illegal grants for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_oh  <= '0;
            sel_bin <= '0;
            gnt_err <= 1'b0;
        end else begin
            gnt_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_gnt != '0) begin
                        if (gnt_legal) begin
                            sel_oh  <= arb_gnt;
                            sel_bin <= gnt_bin;
                            state   <= XFER;
                        end else begin
                            gnt_err <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (accept && sel_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output stage: load on accept, otherwise drop valid once drained.
    // The payload is left untouched while stalled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_port  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_port  <= sel_bin;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_arb_mux.sv
// Testbench for pkt_arb_mux. A lowest-index-first arbiter model and per-port
// packet sources drive the design. A transaction-level model of the
// packet-lock and output-stage rules predicts every output each cycle.
module tb_pkt_arb_mux;

    localparam int PORTNUM = 16;
    localparam int DW      = 32;
    localparam int PORT_W  = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [PORTNUM-1:0]    in_valid;
    logic [PORTNUM*DW-1:0] in_data;
    logic [PORTNUM-1:0]    in_last;
    logic [PORTNUM-1:0]    in_ready;
    logic [PORTNUM-1:0]    arb_req;
    logic                  arb_schedule_en;
    logic [PORTNUM-1:0]    arb_gnt;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic [PORT_W-1:0]     out_port;
    logic                  out_ready;
    logic                  gnt_err;

    pkt_arb_mux #(
        .PORTNUM (PORTNUM),
        .DW      (DW),
        .PORT_W  (PORT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .arb_req         (arb_req),
        .arb_schedule_en (arb_schedule_en),
        .arb_gnt         (arb_gnt),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_port        (out_port),
        .out_ready       (out_ready),
        .gnt_err         (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter stand-in: the lowest requesting index wins unless a forced
    // grant is being injected.
    logic               gnt_force;
    logic [PORTNUM-1:0] gnt_force_val;
    always_comb begin
        arb_gnt = '0;
        if (gnt_force) begin
            arb_gnt = gnt_force_val;
        end else begin
            for (int i = PORTNUM - 1; i >= 0; i--) begin
                if (arb_req[i]) begin
                    arb_gnt    = '0;
                    arb_gnt[i] = 1'b1;
                end
            end
        end
    end

    beat_t              src_q[PORTNUM][$];
    logic [PORTNUM-1:0] src_en;

    int             m_busy;
    logic           m_ov;
    logic [DW-1:0]  m_od;
    logic           m_ol;
    logic [PORT_W-1:0] m_op;
    logic           m_err;

    logic [PORTNUM-1:0] s_valid;
    logic [PORTNUM-1:0] s_gnt;
    logic               s_load_ok;
    logic               s_oready;
    logic               s_rst;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int sent_beats = 0;
    int delivered = 0;
    int err_pulses = 0;
    int delivered_port[PORTNUM];
    int first_out[PORTNUM];
    int last_out[PORTNUM];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_packet(input int p, input int len, input logic [DW-1:0] base, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = rnd ? DW'($urandom) : base + DW'(k);
            b.l = (k == len - 1);
            src_q[p].push_back(b);
        end
        sent_beats += len;
    endtask

    // Each enabled source presents the head of its queue. Idle lanes carry
    // junk data so that a mux selecting the wrong port shows up.
    task automatic drive_inputs();
        for (int p = 0; p < PORTNUM; p++) begin
            if (src_en[p] && src_q[p].size() > 0) begin
                in_valid[p]          = 1'b1;
                in_data[p*DW +: DW]  = src_q[p][0].d;
                in_last[p]           = src_q[p][0].l;
            end else begin
                in_valid[p]          = 1'b0;
                in_data[p*DW +: DW]  = DW'($urandom);
                in_last[p]           = 1'($urandom_range(0, 1));
            end
        end
    endtask

    function automatic bit all_idle();
        bit empty;
        empty = 1'b1;
        for (int p = 0; p < PORTNUM; p++) begin
            if (src_q[p].size() != 0) empty = 1'b0;
        end
        return empty && (m_busy < 0) && !m_ov;
    endfunction

    task automatic clear_tracking();
        for (int p = 0; p < PORTNUM; p++) begin
            delivered_port[p] = 0;
            first_out[p]      = -1;
            last_out[p]       = -1;
        end
    endtask

    // Compare every DUT output against the model and capture what the model
    // needs to advance across the coming edge.
    task automatic check_output();
        logic               load_ok;
        logic [PORTNUM-1:0] exp_ready;
        logic [PORTNUM-1:0] exp_req;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data",  64'(out_data),  64'(m_od));
        check("out_last",  64'(out_last),  64'(m_ol));
        check("out_port",  64'(out_port),  64'(m_op));
        check("gnt_err",   64'(gnt_err),   64'(m_err));
        load_ok   = !m_ov || out_ready;
        exp_ready = '0;
        if (m_busy >= 0 && load_ok) exp_ready[m_busy] = 1'b1;
        exp_req   = (m_busy < 0) ? in_valid : '0;
        check("in_ready",        64'(in_ready),        64'(exp_ready));
        check("arb_req",         64'(arb_req),         64'(exp_req));
        check("arb_schedule_en", 64'(arb_schedule_en), 64'((m_busy < 0) && (in_valid != '0)));
        if (gnt_err === 1'b1) err_pulses++;
        if (m_ov && first_out[m_op] < 0) first_out[m_op] = cycle;
        if (m_ov && out_ready) begin
            delivered++;
            delivered_port[m_op]++;
            last_out[m_op] = cycle;
        end
        s_valid   = in_valid;
        s_gnt     = arb_gnt;
        s_load_ok = load_ok;
        s_oready  = out_ready;
        s_rst     = rst;
    endtask

    // Packet-lock model: a locked port moves one beat per cycle while the
    // output stage has room; a legal grant in idle locks a port, any other
    // nonzero grant raises the error flag for a single cycle.
    task automatic update_model();
        beat_t b;
        bit    was_idle;
        int    g;
        if (s_rst) begin
            m_busy = -1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_op = '0; m_err = 1'b0;
            return;
        end
        was_idle = (m_busy < 0);
        m_err    = 1'b0;
        if (!was_idle && s_valid[m_busy] && s_load_ok) begin
            b    = src_q[m_busy].pop_front();
            m_ov = 1'b1;
            m_od = b.d;
            m_ol = b.l;
            m_op = PORT_W'(m_busy);
            if (b.l) m_busy = -1;
        end else if (s_oready) begin
            m_ov = 1'b0;
        end
        if (was_idle && s_gnt != '0) begin
            if ($onehot(s_gnt) && ((s_gnt & ~s_valid) == '0)) begin
                g = 0;
                for (int i = 0; i < PORTNUM; i++) if (s_gnt[i]) g = i;
                m_busy = g;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus();
        drive_inputs();
        #1;
        check_output();
        @(posedge clk);
        update_model();
        @(negedge clk);
        cycle++;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!all_idle() && n < limit) begin
            apply_stimulus();
            n++;
        end
        check("drain_done", 64'(all_idle()), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k0;
        int n;
        rst           = 1'b1;
        gnt_force     = 1'b0;
        gnt_force_val = '0;
        src_en        = '1;
        out_ready     = 1'b1;
        in_valid      = '0;
        in_data       = '0;
        in_last       = '0;
        clear_tracking();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_busy = -1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_op = '0; m_err = 1'b0;
        rst = 1'b0;
        apply_stimulus();

        // Single 4-beat packet on port 3; out_valid is up in the third cycle
        // counting the in_valid cycle as the first.
        clear_tracking();
        push_packet(3, 4, 32'hD000_0000, 1'b0);
        k0 = cycle;
        apply_stimulus();
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            apply_stimulus();
            n++;
        end
        check("first_beat_latency", 64'(cycle - k0), 64'(2));
        drain(20);
        check("port3_beats", 64'(delivered_port[3]), 64'(4));

        // Ports 2 and 5 contend; port 2 wins, then a bubble, then port 5.
        clear_tracking();
        push_packet(2, 2, 32'h2200_0000, 1'b0);
        push_packet(5, 2, 32'h5500_0000, 1'b0);
        drain(30);
        check("p2_before_p5", 64'(last_out[2] < first_out[5]), 64'(1));
        check("arb_bubble",   64'(first_out[5] - last_out[2] >= 2), 64'(1));
        check("p5_beats",     64'(delivered_port[5]), 64'(2));

        // Three-cycle downstream stall in the middle of a 6-beat packet.
        clear_tracking();
        push_packet(7, 6, 32'h7700_0000, 1'b0);
        n = 0;
        while (delivered_port[7] < 2 && n < 20) begin
            apply_stimulus();
            n++;
        end
        out_ready = 1'b0;
        repeat (3) apply_stimulus();
        out_ready = 1'b1;
        drain(30);
        check("p7_beats", 64'(delivered_port[7]), 64'(6));

        // Illegal grants while only port 0 requests: two-hot, then one-hot on
        // an idle port. Each must pulse the error flag and latch nothing.
        clear_tracking();
        err_pulses = 0;
        push_packet(0, 1, 32'h0000_00A0, 1'b0);
        gnt_force     = 1'b1;
        gnt_force_val = 16'h0003;
        apply_stimulus();
        gnt_force_val = 16'h0010;
        apply_stimulus();
        gnt_force = 1'b0;
        check("illegal_no_beat", 64'(out_valid), 64'(0));
        drain(20);
        check("illegal_pulses", 64'(err_pulses), 64'(2));
        check("p0_after_illegal", 64'(delivered_port[0]), 64'(1));

        // Reset after two beats of port 4, then a clean packet from port 9.
        clear_tracking();
        push_packet(4, 4, 32'h4400_0000, 1'b0);
        n = 0;
        while (delivered_port[4] < 2 && n < 20) begin
            apply_stimulus();
            n++;
        end
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        for (int p = 0; p < PORTNUM; p++) src_q[p].delete();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        push_packet(9, 3, 32'h9900_0000, 1'b0);
        drain(30);
        check("p4_abandoned", 64'(delivered_port[4] <= 3), 64'(1));
        check("p9_beats", 64'(delivered_port[9]), 64'(3));

        // Highest port index, single-beat packet.
        clear_tracking();
        push_packet(15, 1, 32'h0000_F00D, 1'b0);
        drain(20);
        check("p15_beats", 64'(delivered_port[15]), 64'(1));

        // Random packets, random source gaps and random downstream stalls.
        clear_tracking();
        sent_beats = 0;
        delivered  = 0;
        for (int k = 0; k < 60; k++) begin
            push_packet($urandom_range(0, PORTNUM - 1), $urandom_range(1, 4), '0, 1'b1);
        end
        n = 0;
        while (!all_idle() && n < 3000) begin
            src_en    = PORTNUM'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus();
            n++;
        end
        src_en    = '1;
        out_ready = 1'b1;
        drain(300);
        check("random_all_delivered", 64'(delivered), 64'(sent_beats));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
